// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage core.
// Handles jr redirects, hazard stalls and outstanding instruction-memory requests.
module if_stage_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_IF,
  input  logic              PC_Src,
  input  logic              flush,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [31:0]       Instruction_ID,
  output logic [ADDR_W-1:0] PC_plus4_ID,
  output logic              valid_ID
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;
  localparam logic [ADDR_W-1:0] FOUR       = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tgt_reg;
  logic [31:0]       buf_instr;
  logic [ADDR_W-1:0] buf_pc4;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_plus4;

  assign redirect = PC_Src & flush;
  assign target   = jump_target & ALIGN_MASK;
  assign pc_plus4 = pc + FOUR;

  // The address is held at pc until the memory answers, so an outstanding request never moves.
  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= PC_INIT;
      tgt_reg        <= '0;
      buf_instr      <= '0;
      buf_pc4        <= '0;
      Instruction_ID <= '0;
      PC_plus4_ID    <= '0;
      valid_ID       <= 1'b0;
    end else begin
      if (redirect) begin
        Instruction_ID <= '0;
        PC_plus4_ID    <= '0;
        valid_ID       <= 1'b0;
      end
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redirect) begin
            if (imem_ready) begin
              pc <= target;
            end else begin
              tgt_reg <= target;
              state   <= DROP;
            end
          end else if (imem_ready) begin
            if (stall_IF) begin
              buf_instr <= imem_rdata;
              buf_pc4   <= pc_plus4;
              state     <= HOLD;
            end else begin
              Instruction_ID <= imem_rdata;
              PC_plus4_ID    <= pc_plus4;
              valid_ID       <= 1'b1;
            end
            pc <= pc_plus4;
          end else if (!stall_IF) begin
            Instruction_ID <= '0;
            PC_plus4_ID    <= '0;
            valid_ID       <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (!stall_IF) begin
            Instruction_ID <= buf_instr;
            PC_plus4_ID    <= buf_pc4;
            valid_ID       <= 1'b1;
            state          <= FETCH;
          end
        end
        // Waiting out a request that was redirected away from; its data is thrown away.
        DROP: begin
          if (redirect) begin
            if (imem_ready) begin
              pc    <= target;
              state <= FETCH;
            end else begin
              tgt_reg <= target;
            end
          end else if (imem_ready) begin
            pc    <= tgt_reg;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
